pendigits_bnn_bp: RTL and testbench

PENDIGITS_BNN_BP -- requirements
Module: pendigits_bnn_bp

---
 rtl/pendigits_bnn_pkg.sv | 37 +++
 rtl/bnn_argmax.sv | 31 +++
 rtl/pendigits_bnn_bp.sv | 65 ++++++
 tb/tb_pendigits_bnn_bp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pendigits_bnn_pkg.sv
// Shared dimensions, datapath widths and the trained default weights for the
// pendigits binary neural network classifier.
package pendigits_bnn_pkg;

    localparam int BNN_N = 16;
    localparam int BNN_B = 4;
    localparam int BNN_M = 40;
    localparam int BNN_C = 10;

    // 16 features of at most 15 give |sum| <= 240, which fits a 9-bit signed value
    localparam int SUM_W   = 9;
    localparam int SCORE_W = 6;

    // Row j holds the input weights of hidden neuron j; bit i is feature i
    localparam logic [BNN_M-1:0][BNN_N-1:0] W1_DEFAULT = {
        16'h6489, 16'h9E5A, 16'h12F3, 16'hC70B, 16'hA64E, 16'h39D4, 16'hE2B1, 16'h5D68,
        16'h8C07, 16'h1A3F, 16'hF94C, 16'h61B5, 16'hD87A, 16'h4E95, 16'hB3CE, 16'h7F20,
        16'h0D6B, 16'hA17E, 16'h58C1, 16'hE4A7, 16'h36F9, 16'h9B14, 16'hC5E6, 16'h2A9D,
        16'h73C8, 16'hE81F, 16'h1DE2, 16'hB54A, 16'h4CB3, 16'h8E71, 16'h27B8, 16'hD14E,
        16'h6B2D, 16'h0FF0, 16'h9669, 16'hC33C, 16'h5A5A, 16'hF00F, 16'h3C96, 16'hA5C3
    };

    localparam logic signed [BNN_M-1:0][SUM_W-1:0] T1_DEFAULT = {
        9'sd7,   -9'sd12, 9'sd3,   -9'sd5,  9'sd9,   9'sd0,   -9'sd8,  9'sd15,
        -9'sd14, 9'sd5,   -9'sd1,  9'sd13,  -9'sd10, 9'sd11,  -9'sd3,  9'sd6,
        9'sd8,   -9'sd17, 9'sd2,   -9'sd9,  9'sd16,  9'sd4,   -9'sd13, 9'sd10,
        -9'sd6,  9'sd1,   -9'sd19, 9'sd7,   -9'sd2,  9'sd14,  9'sd5,   -9'sd11,
        9'sd18,  -9'sd4,  9'sd9,   9'sd0,   -9'sd15, 9'sd3,   -9'sd7,  9'sd12
    };

    // Row c holds the hidden-to-class weights of class c; bit j is neuron j
    localparam logic [BNN_C-1:0][BNN_M-1:0] W2_DEFAULT = {
        40'h0B62D8E5A3, 40'hC14E7B9268, 40'h37D94AF0B5, 40'hE8B5263C91, 40'h6A0FE17D38,
        40'hD5934B2A6C, 40'h1F6A83C9E7, 40'hB27C09E54D, 40'h4E81D6A3F0, 40'h9C3A5E17B2
    };

endpackage

// File: rtl/bnn_argmax.sv
// Picks the index of the largest class score; on equal scores the lowest
// index is kept because only a strictly greater score replaces the leader.
module bnn_argmax
    import pendigits_bnn_pkg::*;
#(
    parameter int C = BNN_C,
    parameter int W = SCORE_W
) (
    input  logic [C*W-1:0]         scores,
    output logic [$clog2(C)-1:0]   idx
);

    localparam int IW = $clog2(C);

    logic [W-1:0]  best_val;
    logic [IW-1:0] best_idx;

    always_comb begin
        best_val = scores[W-1:0];
        best_idx = '0;
        for (int c = 1; c < C; c++) begin
            if (scores[c*W +: W] > best_val) begin
                best_val = scores[c*W +: W];
                best_idx = IW'(c);
            end
        end
    end

    assign idx = best_idx;

endmodule

// File: rtl/pendigits_bnn_bp.sv
// Single-cycle binary neural network: signed-sum hidden layer, XNOR-popcount
// class scores and argmax, with the class index registered once per clock.
module pendigits_bnn_bp
    import pendigits_bnn_pkg::*;
#(
    parameter int N = BNN_N,
    parameter int B = BNN_B,
    parameter int M = BNN_M,
    parameter int C = BNN_C,
    parameter logic [M*N-1:0]     W1 = W1_DEFAULT,
    parameter logic [M*SUM_W-1:0] T1 = T1_DEFAULT,
    parameter logic [C*M-1:0]     W2 = W2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*B-1:0]        inp,
    output logic [$clog2(C)-1:0]  klass
);

    logic [M-1:0]         hidden;
    logic [C*SCORE_W-1:0] scores;
    logic [$clog2(C)-1:0] klass_d;
    logic [$clog2(C)-1:0] klass_q;

    for (genvar j = 0; j < M; j++) begin : g_hidden
        logic signed [SUM_W-1:0] sum;

        always_comb begin
            sum = '0;
            for (int i = 0; i < N; i++) begin
                if (W1[j*N+i]) begin
                    sum = sum + $signed({{(SUM_W-B){1'b0}}, inp[B*i +: B]});
                end else begin
                    sum = sum - $signed({{(SUM_W-B){1'b0}}, inp[B*i +: B]});
                end
            end
        end

        assign hidden[j] = (sum >= $signed(T1[SUM_W*j +: SUM_W]));
    end

    // Matching bits between the hidden vector and a class row count as agreement
    for (genvar c = 0; c < C; c++) begin : g_score
        assign scores[c*SCORE_W +: SCORE_W] = SCORE_W'($countones(~(hidden ^ W2[c*M +: M])));
    end

    bnn_argmax #(
        .C (C),
        .W (SCORE_W)
    ) u_argmax (
        .scores (scores),
        .idx    (klass_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klass_q <= '0;
        end else begin
            klass_q <= klass_d;
        end
    end

    assign klass = klass_q;

endmodule

// File: tb/tb_pendigits_bnn_bp.sv
// Directed bench for pendigits_bnn_bp: weight-override corner cases, reset
// behaviour, a back-to-back stream and a random regression against a model.
module tb_pendigits_bnn_bp;
    import pendigits_bnn_pkg::*;

    localparam int NB = BNN_N * BNN_B;

    localparam logic [BNN_M*BNN_N-1:0] W1_ONES = {(BNN_M*BNN_N){1'b1}};
    localparam logic [BNN_M*BNN_N-1:0] W1_ZERO = {(BNN_M*BNN_N){1'b0}};
    localparam logic [BNN_M*SUM_W-1:0] T1_ZERO = {(BNN_M*SUM_W){1'b0}};
    localparam logic [BNN_M*SUM_W-1:0] T1_100  = {BNN_M{9'd100}};

    localparam logic [BNN_C*BNN_M-1:0] W2_A = {{(6*BNN_M){1'b0}}, {BNN_M{1'b1}}, {(3*BNN_M){1'b0}}};
    localparam logic [BNN_C*BNN_M-1:0] W2_B = {{(2*BNN_M){1'b0}}, {BNN_M{1'b1}}, {(3*BNN_M){1'b0}},
                                               {BNN_M{1'b1}}, {(3*BNN_M){1'b0}}};
    localparam logic [BNN_C*BNN_M-1:0] W2_C = {{BNN_M{1'b0}}, {(9*BNN_M){1'b1}}};
    localparam logic [BNN_C*BNN_M-1:0] W2_D = {{(4*BNN_M){1'b0}}, {BNN_M{1'b1}}, {(5*BNN_M){1'b0}}};

    localparam logic [BNN_M*BNN_N-1:0] W1_M = W1_DEFAULT;
    localparam logic [BNN_M*SUM_W-1:0] T1_M = T1_DEFAULT;
    localparam logic [BNN_C*BNN_M-1:0] W2_M = W2_DEFAULT;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] inp;
    logic [3:0]    klass_def, klass_a, klass_b, klass_c, klass_d;

    int n_compared;
    int n_mismatched;

    pendigits_bnn_bp u_dut_def (
        .clk (clk), .rst_n (rst_n), .inp (inp), .klass (klass_def)
    );

    pendigits_bnn_bp #(.W1(W1_ONES), .T1(T1_ZERO), .W2(W2_A)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .inp (inp), .klass (klass_a)
    );

    pendigits_bnn_bp #(.W1(W1_ONES), .T1(T1_ZERO), .W2(W2_B)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .inp (inp), .klass (klass_b)
    );

    pendigits_bnn_bp #(.W1(W1_ZERO), .T1(T1_ZERO), .W2(W2_C)) u_dut_c (
        .clk (clk), .rst_n (rst_n), .inp (inp), .klass (klass_c)
    );

    pendigits_bnn_bp #(.W1(W1_ONES), .T1(T1_100), .W2(W2_D)) u_dut_d (
        .clk (clk), .rst_n (rst_n), .inp (inp), .klass (klass_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference of the network using the default package weights
    function automatic logic [3:0] model_class(input logic [NB-1:0] v);
        logic [BNN_M-1:0] h;
        int s, t, cnt, best;
        logic [3:0] bi;
        for (int j = 0; j < BNN_M; j++) begin
            s = 0;
            for (int i = 0; i < BNN_N; i++) begin
                if (W1_M[j*BNN_N+i]) s = s + int'(v[BNN_B*i +: BNN_B]);
                else                 s = s - int'(v[BNN_B*i +: BNN_B]);
            end
            t = int'($signed(T1_M[SUM_W*j +: SUM_W]));
            h[j] = (s >= t);
        end
        best = -1;
        bi = 4'd0;
        for (int c = 0; c < BNN_C; c++) begin
            cnt = 0;
            for (int j = 0; j < BNN_M; j++) begin
                if (h[j] == W2_M[c*BNN_M+j]) cnt++;
            end
            if (cnt > best) begin
                best = cnt;
                bi = 4'(c);
            end
        end
        return bi;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NB-1:0] v;
        logic [3:0] exp;
        rst_n = 1'b1;
        inp = '0;
        #1 rst_n = 1'b0;
        step();
        n_compared++;
        if (klass_def !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_def: got %0d expected 0", klass_def); end
        n_compared++;
        if (klass_a !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_a: got %0d expected 0", klass_a); end
        n_compared++;
        if (klass_c !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_c: got %0d expected 0", klass_c); end
        for (int k = 0; k < 3; k++) begin
            inp = {$urandom, $urandom};
            step();
            n_compared++;
            if (klass_a !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_hold_a: got %0d expected 0", klass_a); end
            n_compared++;
            if (klass_c !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_hold_c: got %0d expected 0", klass_c); end
        end
        v = 64'h8f4d96400498fe6f;
        exp = model_class(v);
        inp = v;
        rst_n = 1'b1;
        step();
        n_compared++;
        if (klass_def !== exp) begin n_mismatched++; $display("[TB] FAIL release_def: got %0d expected %0d", klass_def, exp); end
        n_compared++;
        if (klass_a !== 4'd3) begin n_mismatched++; $display("[TB] FAIL release_a: got %0d expected 3", klass_a); end
    endtask

    task automatic test_hidden_all_on();
        inp = 64'h0;
        step();
        n_compared++;
        if (klass_a !== 4'd3) begin n_mismatched++; $display("[TB] FAIL all_on_zero_a: got %0d expected 3", klass_a); end
        n_compared++;
        if (klass_c !== 4'd0) begin n_mismatched++; $display("[TB] FAIL zero_c: got %0d expected 0", klass_c); end
        inp = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        n_compared++;
        if (klass_a !== 4'd3) begin n_mismatched++; $display("[TB] FAIL all_on_max_a: got %0d expected 3", klass_a); end
    endtask

    task automatic test_tie();
        inp = 64'h1234_5678_9ABC_DEF0;
        step();
        n_compared++;
        if (klass_b !== 4'd3) begin n_mismatched++; $display("[TB] FAIL tie_mixed_b: got %0d expected 3", klass_b); end
        inp = 64'h0;
        step();
        n_compared++;
        if (klass_b !== 4'd3) begin n_mismatched++; $display("[TB] FAIL tie_zero_b: got %0d expected 3", klass_b); end
    endtask

    task automatic test_all_off();
        inp = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        n_compared++;
        if (klass_c !== 4'd9) begin n_mismatched++; $display("[TB] FAIL all_off_max_c: got %0d expected 9", klass_c); end
        inp = 64'h1;
        step();
        n_compared++;
        if (klass_c !== 4'd9) begin n_mismatched++; $display("[TB] FAIL all_off_one_c: got %0d expected 9", klass_c); end
    endtask

    // Feature sum exactly at, just below and far above a threshold of 100
    task automatic test_threshold();
        logic [NB-1:0] vecs [4];
        logic [3:0]    exps [4];
        vecs[0] = 64'h0000_0000_0AFF_FFFF; exps[0] = 4'd5;
        vecs[1] = 64'h0000_0000_09FF_FFFF; exps[1] = 4'd0;
        vecs[2] = 64'hFFFF_FFFF_FFFF_FFFF; exps[2] = 4'd5;
        vecs[3] = 64'h0000_0000_0000_0000; exps[3] = 4'd0;
        for (int k = 0; k < 4; k++) begin
            inp = vecs[k];
            step();
            n_compared++;
            if (klass_d !== exps[k]) begin
                n_mismatched++;
                $display("[TB] FAIL threshold_%0d: got %0d expected %0d", k, klass_d, exps[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] vecs [5];
        logic [3:0] exp;
        vecs[0] = 64'h8f4d96400498fe6f;
        vecs[1] = 64'h0e4f7c572260b0f1;
        vecs[2] = 64'h095bceffcc884430;
        vecs[3] = 64'h0f1f1b37e5f7c4b0;
        vecs[4] = 64'h0b8dffddaa665380;
        inp = vecs[0];
        for (int k = 0; k < 5; k++) begin
            step();
            exp = model_class(vecs[k]);
            n_compared++;
            if (klass_def !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL stream_%0d: got %0d expected %0d", k, klass_def, exp);
            end
            if (k < 4) inp = vecs[k+1];
        end
    endtask

    task automatic test_async_reset();
        logic [NB-1:0] v;
        logic [3:0] exp;
        inp = 64'h0;
        step();
        n_compared++;
        if (klass_a !== 4'd3) begin n_mismatched++; $display("[TB] FAIL pre_async_a: got %0d expected 3", klass_a); end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if (klass_a !== 4'd0) begin n_mismatched++; $display("[TB] FAIL async_clear_a: got %0d expected 0", klass_a); end
        inp = 64'h0e4f7c572260b0f1;
        step();
        n_compared++;
        if (klass_a !== 4'd0) begin n_mismatched++; $display("[TB] FAIL async_hold_a: got %0d expected 0", klass_a); end
        v = 64'h095bceffcc884430;
        exp = model_class(v);
        inp = v;
        #2 rst_n = 1'b1;
        #1;
        n_compared++;
        if (klass_a !== 4'd0) begin n_mismatched++; $display("[TB] FAIL async_release_a: got %0d expected 0", klass_a); end
        step();
        n_compared++;
        if (klass_def !== exp) begin n_mismatched++; $display("[TB] FAIL async_first_def: got %0d expected %0d", klass_def, exp); end
        n_compared++;
        if (klass_a !== 4'd3) begin n_mismatched++; $display("[TB] FAIL async_first_a: got %0d expected 3", klass_a); end
    endtask

    task automatic test_random();
        logic [NB-1:0] v;
        logic [3:0] exp;
        v = {$urandom, $urandom};
        inp = v;
        for (int k = 0; k < 10000; k++) begin
            step();
            exp = model_class(v);
            n_compared++;
            if (klass_def !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL random_%0d: got %0d expected %0d", k, klass_def, exp);
            end
            v = {$urandom, $urandom};
            inp = v;
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        test_reset();
        test_hidden_all_on();
        test_tie();
        test_all_off();
        test_threshold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
